fp_mul_out_stage: RTL and testbench

- Registered output stage directly downstream of the combinational fp multiplier.
- Takes the multiplier's sign/exp/frac/overflow result plus an upstream zero-operand flag, and applies special-case fix-up (signed zero, ±inf on overflow).
- Packs the result into a single word and buffers it in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Keeps sticky exception flags for the result writer / CSR block.

---
 rtl/fp_mul_out_stage.sv | 184 ++++++++++++++++++
 tb/tb_fp_mul_out_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_out_stage.sv
// fp_mul_out_stage: registered output stage for the combinational fp multiplier.
//   Applies special-case fix-up: signed zero wins over overflow, and overflow
//   becomes +/-inf. The fixed-up result is packed as {sign, exp, frac} and
//   buffered in a 2-entry skid FIFO with valid/ready on both sides. The stage
//   also keeps sticky exception flags and an optional count of results
//   handed downstream.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready depends only on state
//   in_sign/exp/frac    multiplier result fields
//   in_overflow         multiplier exponent overflow
//   in_zero             an operand was zero
//   out_valid/out_ready downstream handshake
//   out_data/out_ovf    head FIFO entry and its overflow flag
//   sticky_ovf/zero     sticky exception flags, cleared by clr_sticky
//   result_cnt          results popped downstream, wrapping
// Build option:
//   FP_OUT_STAGE_CNT_EN  when defined, result_cnt is a live counter;
//                        otherwise it is tied to zero.
module fp_mul_out_stage #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 7,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sign,
  input  logic [EXP_WIDTH-1:0]              in_exp,
  input  logic [FRAC_WIDTH-1:0]             in_frac,
  input  logic                              in_overflow,
  input  logic                              in_zero,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]     out_data,
  output logic                              out_ovf,
  output logic                              sticky_ovf,
  output logic                              sticky_zero,
  input  logic                              clr_sticky,
  output logic [CNT_WIDTH-1:0]              result_cnt
);

  localparam int unsigned DATA_W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned COUNT_W = 2;

  // FIFO state
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0]   ovf_q;
  logic [DEPTH-1:0]   ovf_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               rd_ptr_q;
  logic               rd_ptr_d;
  logic               wr_ptr_q;
  logic               wr_ptr_d;

  // Sticky flags
  logic sticky_ovf_q;
  logic sticky_ovf_d;
  logic sticky_zero_q;
  logic sticky_zero_d;

  // Handshake and fixed-up entry
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] entry_data_c;
  logic              entry_ovf_c;

  // Ready depends only on the registered occupancy, never on out_ready.
  assign in_ready  = (count_q != COUNT_W'(DEPTH));
  assign out_valid = (count_q != COUNT_W'(0));
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  // The head entry register drives the outputs directly.
  assign out_data    = data_q[rd_ptr_q];
  assign out_ovf     = ovf_q[rd_ptr_q];
  assign sticky_ovf  = sticky_ovf_q;
  assign sticky_zero = sticky_zero_q;

  // Special-case fix-up; a zero operand overrides an exponent overflow.
  always_comb begin
    entry_data_c = {in_sign, in_exp, in_frac};
    entry_ovf_c  = 1'b0;
    if (in_zero) begin
      entry_data_c = {in_sign, EXP_WIDTH'(0), FRAC_WIDTH'(0)};
    end else if (in_overflow) begin
      entry_data_c = {in_sign, {EXP_WIDTH{1'b1}}, FRAC_WIDTH'(0)};
      entry_ovf_c  = 1'b1;
    end
  end

  // FIFO next state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    data_d   = data_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (push_c) begin
      data_d[wr_ptr_q] = entry_data_c;
      ovf_d[wr_ptr_q]  = entry_ovf_c;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky flags; a setting push beats a same-cycle clear.
  always_comb begin
    sticky_ovf_d  = sticky_ovf_q;
    sticky_zero_d = sticky_zero_q;
    if (clr_sticky) begin
      sticky_ovf_d  = 1'b0;
      sticky_zero_d = 1'b0;
    end
    if (push_c && entry_ovf_c) begin
      sticky_ovf_d = 1'b1;
    end
    if (push_c && in_zero) begin
      sticky_zero_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
      ovf_q         <= '0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      sticky_ovf_q  <= 1'b0;
      sticky_zero_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      ovf_q         <= ovf_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      sticky_ovf_q  <= sticky_ovf_d;
      sticky_zero_q <= sticky_zero_d;
    end
  end

`ifdef FP_OUT_STAGE_CNT_EN
  // Count of results handed downstream, wrapping at all-ones.
  logic [CNT_WIDTH-1:0] result_cnt_q;
  logic [CNT_WIDTH-1:0] result_cnt_d;

  always_comb begin
    result_cnt_d = result_cnt_q;
    if (pop_c) begin
      result_cnt_d = result_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt_q <= '0;
    end else begin
      result_cnt_q <= result_cnt_d;
    end
  end

  assign result_cnt = result_cnt_q;
`else
  assign result_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_mul_out_stage.sv
// tb_fp_mul_out_stage: directed plus randomized bench for fp_mul_out_stage.
//   A queue-based reference model tracks the expected FIFO contents, sticky
//   flags and result count; outputs are checked on the falling edge.
module tb_fp_mul_out_stage;

  localparam int unsigned EW = 8;
  localparam int unsigned FW = 7;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 1 + EW + FW;
  localparam int unsigned MW = DW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [FW-1:0] in_frac;
  logic          in_overflow;
  logic          in_zero;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          sticky_ovf;
  logic          sticky_zero;
  logic          clr_sticky;
  logic [CW-1:0] result_cnt;

  fp_mul_out_stage #(
    .EXP_WIDTH (EW),
    .FRAC_WIDTH(FW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_frac    (in_frac),
    .in_overflow(in_overflow),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .sticky_ovf (sticky_ovf),
    .sticky_zero(sticky_zero),
    .clr_sticky (clr_sticky),
    .result_cnt (result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: entries are {ovf, data}
  logic [MW-1:0] mq [$];
  bit            m_sov;
  bit            m_sz;
  int unsigned   m_cnt;
  bit            m_after_rst;
  bit            m_pushed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected packed result from the fix-up rules, in plain arithmetic.
  function automatic logic [MW-1:0] fixup(input logic s, input logic [EW-1:0] e,
                                          input logic [FW-1:0] f, input logic o,
                                          input logic z);
    int unsigned w;
    w = s ? (2 ** (EW + FW)) : 0;
    if (z) return MW'(w);
    if (o) return MW'((2 ** DW) + w + ((2 ** EW) - 1) * (2 ** FW));
    return MW'(w + int'(e) * (2 ** FW) + int'(f));
  endfunction

  task automatic check_outputs();
    logic [MW-1:0] head;
    int unsigned   want_cnt;
`ifdef FP_OUT_STAGE_CNT_EN
    want_cnt = m_cnt % (2 ** CW);
`else
    want_cnt = 0;
`endif
    check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_val("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() != 0) begin
      head = mq[0];
      check_val("out_data", 32'(out_data), 32'(head[DW-1:0]));
      check_val("out_ovf", 32'(out_ovf), 32'(head[DW]));
    end
    if (m_after_rst) begin
      check_val("out_data_rst", 32'(out_data), 32'd0);
      check_val("out_ovf_rst", 32'(out_ovf), 32'd0);
    end
    check_val("sticky_ovf", 32'(sticky_ovf), 32'(m_sov));
    check_val("sticky_zero", 32'(sticky_zero), 32'(m_sz));
    check_val("result_cnt", 32'(result_cnt), want_cnt);
  endtask

  // Advance one clock using the inputs already driven, update model, check.
  task automatic cycle();
    bit            push;
    bit            pop;
    logic [MW-1:0] e;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() != 0) && out_ready;
    e    = fixup(in_sign, in_exp, in_frac, in_overflow, in_zero);
    @(posedge clk);
    m_pushed = 1'b0;
    if (rst) begin
      mq.delete();
      m_sov = 1'b0;
      m_sz  = 1'b0;
      m_cnt = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (clr_sticky) begin
        m_sov = 1'b0;
        m_sz  = 1'b0;
      end
      if (push) begin
        mq.push_back(e);
        m_pushed = 1'b1;
        if (e[DW]) m_sov = 1'b1;
        if (in_zero) m_sz = 1'b1;
      end
    end
    m_after_rst = rst;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic s, input logic [EW-1:0] e,
                       input logic [FW-1:0] f, input logic o, input logic z);
    in_valid    = v;
    in_sign     = s;
    in_exp      = e;
    in_frac     = f;
    in_overflow = o;
    in_zero     = z;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    m_sov       = 1'b0;
    m_sz        = 1'b0;
    m_cnt       = 0;
    m_after_rst = 1'b0;
    m_pushed    = 1'b0;
    rst         = 1'b1;
    out_ready   = 1'b1;
    clr_sticky  = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset then idle
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check_val("idle_data", 32'(out_data), 32'h0000);

    // Single normal push
    drive(1'b1, 1'b0, 8'h80, 7'h40, 1'b0, 1'b0);
    cycle();
    check_val("single_data", 32'(out_data), 32'h4040);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // Overflow becomes -inf; then clear the sticky flag
    drive(1'b1, 1'b1, 8'h12, 7'h33, 1'b1, 1'b0);
    cycle();
    check_val("ovf_data", 32'(out_data), 32'hFF80);
    check_val("ovf_sticky", 32'(sticky_ovf), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    check_val("clr_sticky", 32'(sticky_ovf), 32'd0);

    // Zero wins over overflow
    drive(1'b1, 1'b1, 8'h55, 7'h11, 1'b1, 1'b1);
    cycle();
    check_val("zero_data", 32'(out_data), 32'h8000);
    check_val("zero_ovf", 32'(out_ovf), 32'd0);
    check_val("zero_sticky", 32'(sticky_zero), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // Same-cycle clear and setting push: set wins
    drive(1'b1, 1'b0, 8'h01, 7'h02, 1'b1, 1'b0);
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // Back-pressure: A and B accepted, C held until there is room
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h10, 7'h01, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 8'h20, 7'h02, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 8'h30, 7'h03, 1'b0, 1'b0);
    cycle();
    cycle();
    check_val("full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4 && !m_pushed; i++) cycle();
    check_val("c_accepted", 32'(m_pushed), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Streaming, then reset with two entries buffered
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 8'($urandom), 7'($urandom), 1'b0, 1'b0);
      cycle();
    end
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 1'b0, 8'h7F, 7'h7F, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 7'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 6) == 0));
      out_ready  = 1'($urandom_range(0, 3) != 0);
      clr_sticky = 1'($urandom_range(0, 15) == 0);
      rst        = 1'($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
